// File: rtl/imem_byte_fetcher.sv
// Byte-serial Y86-64 instruction fetcher: reads one byte at a time from PC and assembles up to 10 bytes.
// Latency: len capture cycles + 1 present cycle; backpressure: instruction held (no mem_req) until instr_ready.
module imem_byte_fetcher #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [79:0]       instruction,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [63:0]       valC,
    output logic [ADDR_W-1:0] valP,
    output logic              instr_err,
    output logic              halted
);

    typedef enum logic [1:0] {
        S_FETCH0,
        S_FETCHN,
        S_PRESENT,
        S_HALTED
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_armed;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_valp;
    logic [3:0]        r_idx;
    logic [3:0]        r_len;
    logic [79:0]       r_instr;
    logic              r_err;

    logic              w_req;
    logic              w_cap;
    logic              w_accept;
    logic [3:0]        w_len0;
    logic              w_bad0;
    logic [3:0]        w_len_cap;
    logic [6:0]        w_bitpos;
    logic [3:0]        w_icode;
    logic              w_has_reg;
    logic [63:0]       w_valc;

    function automatic logic [3:0] len_of(input logic [3:0] ic);
        case (ic)
            4'h0, 4'h1, 4'h9:       return 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: return 4'd2;
            4'h7, 4'h8:             return 4'd9;
            4'h3, 4'h4, 4'h5:       return 4'd10;
            default:                return 4'd1;
        endcase
    endfunction

    // r_armed keeps mem_req low until the first edge after reset release
    assign w_req     = r_armed && ((r_state == S_FETCH0) || (r_state == S_FETCHN));
    assign w_cap     = w_req && mem_ack;
    assign w_accept  = (r_state == S_PRESENT) && instr_ready;
    assign w_len0    = len_of(mem_rdata[7:4]);
    assign w_bad0    = (mem_rdata[7:4] > 4'hB);
    assign w_len_cap = w_bad0 ? 4'd1 : w_len0;
    assign w_bitpos  = 7'd79 - {r_idx, 3'b000};
    assign w_icode   = r_instr[79:76];

    always_comb begin
        w_has_reg = 1'b0;
        w_valc    = '0;
        case (w_icode)
            4'h2, 4'h6, 4'hA, 4'hB: w_has_reg = 1'b1;
            4'h3, 4'h4, 4'h5: begin
                w_has_reg = 1'b1;
                w_valc    = r_instr[63:0];
            end
            4'h7, 4'h8:       w_valc = r_instr[71:8];
            default:          w_has_reg = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (pc_load) begin
            w_state_nxt = S_FETCH0;
        end else begin
            case (r_state)
                S_FETCH0: begin
                    if (w_cap) begin
                        w_state_nxt = (w_bad0 || (w_len0 == 4'd1)) ? S_PRESENT : S_FETCHN;
                    end
                end
                S_FETCHN: begin
                    if (w_cap && (r_idx == r_len - 4'd1)) begin
                        w_state_nxt = S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (instr_ready) begin
                        w_state_nxt = ((w_icode == 4'h0) || r_err) ? S_HALTED : S_FETCH0;
                    end
                end
                default: w_state_nxt = S_HALTED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed <= 1'b0;
            r_pc    <= RESET_PC;
            r_valp  <= '0;
            r_idx   <= '0;
            r_len   <= 4'd1;
            r_instr <= '0;
            r_err   <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (pc_load) begin
                r_pc    <= pc_in;
                r_idx   <= '0;
                r_instr <= '0;
                r_err   <= 1'b0;
            end else if ((r_state == S_FETCH0) && w_cap) begin
                r_instr <= {mem_rdata, 72'h0};
                r_len   <= w_len_cap;
                r_err   <= w_bad0;
                r_valp  <= r_pc + {{(ADDR_W-4){1'b0}}, w_len_cap};
                r_idx   <= 4'd1;
            end else if ((r_state == S_FETCHN) && w_cap) begin
                r_instr[w_bitpos -: 8] <= mem_rdata;
                r_idx                  <= r_idx + 4'd1;
            end else if (w_accept) begin
                r_pc  <= r_valp;
                r_err <= 1'b0;
                r_idx <= '0;
            end
        end
    end

    assign mem_req     = w_req;
    assign mem_addr    = r_pc + {{(ADDR_W-4){1'b0}}, r_idx};
    assign instr_valid = (r_state == S_PRESENT);
    assign instruction = r_instr;
    assign icode       = w_icode;
    assign ifun        = r_instr[75:72];
    assign rA          = w_has_reg ? r_instr[71:68] : 4'hF;
    assign rB          = w_has_reg ? r_instr[67:64] : 4'hF;
    assign valC        = w_valc;
    assign valP        = r_valp;
    assign instr_err   = r_err;
    assign halted      = (r_state == S_HALTED);

endmodule

// File: tb/tb_imem_byte_fetcher.sv
// Bench for imem_byte_fetcher: byte-addressed memory model with random ack gaps and an instruction-level reference.
module tb_imem_byte_fetcher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_load = 1'b0;
    logic [63:0] pc_in = '0;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [79:0] instruction;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic        instr_err, halted;

    always #5 clk = ~clk;

    imem_byte_fetcher #(.ADDR_W(64), .RESET_PC(64'd64)) dut (
        .clk(clk), .rst_n(rst_n), .pc_load(pc_load), .pc_in(pc_in),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instruction(instruction),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
        .instr_err(instr_err), .halted(halted)
    );

    typedef struct {
        logic [79:0] ins;
        logic [3:0]  ic, fn, ra, rb;
        logic [63:0] vc, vp;
        logic        err;
        int          len;
    } exp_t;

    logic [7:0]  mem [logic [63:0]];
    int          n_checks = 0;
    int          n_errors = 0;
    int          gap_mode = 0;
    logic        hold_prev = 1'b0;
    logic [63:0] addr_prev = '0;
    int          wait_cnt = 0;
    int          cyc;
    exp_t        e;
    logic [63:0] rpc;

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rd(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'h00;
    endfunction

    // Reference: decode straight from the byte image using the length table
    function automatic exp_t model(input logic [63:0] pc);
        exp_t       r;
        logic [7:0] b0, b1;
        b0 = rd(pc);
        b1 = rd(pc + 64'd1);
        r.ic = b0[7:4];
        r.fn = b0[3:0];
        r.err = 1'b0;
        case (r.ic)
            4'h0, 4'h1, 4'h9:       r.len = 1;
            4'h2, 4'h6, 4'hA, 4'hB: r.len = 2;
            4'h7, 4'h8:             r.len = 9;
            4'h3, 4'h4, 4'h5:       r.len = 10;
            default: begin r.len = 1; r.err = 1'b1; end
        endcase
        r.ins = '0;
        for (int i = 0; i < r.len; i++) r.ins[79-8*i -: 8] = rd(pc + 64'(i));
        r.ra = (r.len == 2 || r.len == 10) ? b1[7:4] : 4'hF;
        r.rb = (r.len == 2 || r.len == 10) ? b1[3:0] : 4'hF;
        r.vc = '0;
        if (r.len == 9)  for (int i = 1; i <= 8; i++) r.vc = {r.vc[55:0], rd(pc + 64'(i))};
        if (r.len == 10) for (int i = 2; i <= 9; i++) r.vc = {r.vc[55:0], rd(pc + 64'(i))};
        r.vp = pc + 64'(r.len);
        return r;
    endfunction

    task automatic put2(input logic [63:0] a, input logic [7:0] b0, input logic [7:0] b1);
        mem[a] = b0;
        mem[a + 64'd1] = b1;
    endtask

    task automatic put9(input logic [63:0] a, input logic [7:0] b0, input logic [63:0] c);
        mem[a] = b0;
        for (int i = 0; i < 8; i++) mem[a + 64'd1 + 64'(i)] = c[63-8*i -: 8];
    endtask

    task automatic put10(input logic [63:0] a, input logic [7:0] b0, input logic [7:0] b1, input logic [63:0] c);
        mem[a] = b0;
        mem[a + 64'd1] = b1;
        for (int i = 0; i < 8; i++) mem[a + 64'd2 + 64'(i)] = c[63-8*i -: 8];
    endtask

    task automatic check_instr(input string tag, input logic [63:0] pc);
        exp_t x;
        x = model(pc);
        chk({tag, ".valid"}, instr_valid, 1'b1);
        chk({tag, ".instruction"}, instruction, x.ins);
        chk({tag, ".icode"}, icode, x.ic);
        chk({tag, ".ifun"}, ifun, x.fn);
        chk({tag, ".valC"}, valC, x.vc);
        chk({tag, ".err"}, instr_err, x.err);
        if (!x.err) begin
            chk({tag, ".rA"}, rA, x.ra);
            chk({tag, ".rB"}, rB, x.rb);
            chk({tag, ".valP"}, valP, x.vp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!instr_valid && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!instr_valid) chk("valid_timeout", 1'b0, 1'b1);
    endtask

    task automatic accept();
        instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        chk("accept.valid_drop", instr_valid, 1'b0);
    endtask

    task automatic do_pc_load(input logic [63:0] a);
        pc_in = a;
        pc_load = 1'b1;
        @(posedge clk); #1;
        pc_load = 1'b0;
        chk("pcload.valid", instr_valid, 1'b0);
        chk("pcload.halted", halted, 1'b0);
    endtask

    task automatic check_halt();
        repeat (3) @(posedge clk);
        #1;
        chk("halt.halted", halted, 1'b1);
        chk("halt.mem_req", mem_req, 1'b0);
        chk("halt.valid", instr_valid, 1'b0);
    endtask

    task automatic run_seq(input logic [63:0] start, input int max_n);
        logic [63:0] pc;
        exp_t        x;
        int          n;
        pc = start;
        for (int k = 0; k < max_n; k++) begin
            wait_valid(n);
            check_instr("seq", pc);
            x = model(pc);
            accept();
            pc = x.vp;
            if (x.ic == 4'h0 || x.err) break;
        end
        check_halt();
    endtask

    // Memory responder: ack decided on the falling edge for the next rising edge
    initial begin
        forever begin
            @(negedge clk);
            if (hold_prev && rst_n) begin
                chk("wait.addr_hold", mem_addr, addr_prev);
                chk("wait.req_hold", mem_req, 1'b1);
            end
            if (gap_mode == 0) begin
                mem_ack = 1'b1;
            end else if (mem_req) begin
                if (wait_cnt > 0) begin
                    mem_ack = 1'b0;
                    wait_cnt--;
                end else begin
                    mem_ack = 1'b1;
                    wait_cnt = $urandom_range(0, 5);
                end
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
            end
            mem_rdata = (mem_ack && mem_req) ? rd(mem_addr) : 8'($urandom);
            hold_prev = mem_req && !mem_ack && !pc_load && rst_n;
            addr_prev = mem_addr;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        put2(64'd64, 8'h20, 8'h23);
        put10(64'd66, 8'h30, 8'hF3, 64'h1F);
        put10(64'd76, 8'h40, 8'h24, 64'h05);
        put2(64'd86, 8'h60, 8'h12);
        mem[64'd88] = 8'h10;
        put9(64'd89, 8'h70, {$urandom, $urandom});
        put2(64'd98, 8'h61, 8'($urandom));
        mem[64'd100] = 8'h90;
        mem[64'd101] = 8'h00;
        mem[64'd200] = 8'hC0;
        put10(64'hFFFF_FFFF_FFFF_FFFC, 8'h30, 8'hF4, 64'h0123_4567_89AB_CDEF);
        mem[64'd6] = 8'h00;
        put10(64'd300, 8'h50, 8'hAB, {$urandom, $urandom});
        put2(64'd400, 8'h60, 8'h45);
        put10(64'd402, 8'h30, 8'hF2, {$urandom, $urandom});
        rpc = 64'd1000;
        for (int k = 0; k < 12; k++) begin
            mem[rpc] = {4'($urandom_range(1, 11)), 4'($urandom)};
            for (int j = 1; j < 10; j++) mem[rpc + 64'(j)] = 8'($urandom);
            e = model(rpc);
            rpc = e.vp;
        end
        mem[rpc] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.mem_req", mem_req, 1'b0);
        chk("rst.valid", instr_valid, 1'b0);
        chk("rst.instruction", instruction, 80'h0);
        chk("rst.icode", icode, 4'h0);
        chk("rst.rA", rA, 4'hF);
        chk("rst.rB", rB, 4'hF);
        chk("rst.valC", valC, 64'h0);
        chk("rst.valP", valP, 64'h0);
        chk("rst.err", instr_err, 1'b0);
        chk("rst.halted", halted, 1'b0);

        // 1: cmovxx at reset PC, zero-wait memory
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t1.req_before_edge", mem_req, 1'b0);
        @(posedge clk); #1;
        chk("t1.req_cycle1", mem_req, 1'b1);
        chk("t1.addr_cycle1", mem_addr, 64'd64);
        wait_valid(cyc);
        chk("t1.latency", 32'(cyc + 1), 32'd3);
        check_instr("t1", 64'd64);
        accept();

        // 2: irmovq, len capture edges from accept
        wait_valid(cyc);
        chk("t2.latency", 32'(cyc), 32'd10);
        check_instr("t2", 64'd66);
        gap_mode = 1;
        accept();

        // 3: rmmovq with random ack gaps
        wait_valid(cyc);
        check_instr("t3", 64'd76);
        gap_mode = 0;
        accept();

        // 4: consumer stalls for 4 cycles
        wait_valid(cyc);
        e = model(64'd86);
        repeat (4) begin
            @(posedge clk); #1;
            chk("t4.valid", instr_valid, 1'b1);
            chk("t4.instruction", instruction, e.ins);
            chk("t4.valP", valP, e.vp);
            chk("t4.rA", rA, e.ra);
            chk("t4.mem_req", mem_req, 1'b0);
        end
        accept();

        // 5: run to halt at 101, then redirect
        run_seq(64'd88, 8);
        chk("t5.pc_after_halt", valP, 64'd102);
        do_pc_load(64'd64);
        wait_valid(cyc);
        chk("t5.reload_latency", 32'(cyc), 32'd2);
        check_instr("t5.reload", 64'd64);

        // 6: redirect while presenting with ready high drops it; C0 is an error
        pc_in = 64'd200;
        pc_load = 1'b1;
        instr_ready = 1'b1;
        @(posedge clk); #1;
        pc_load = 1'b0;
        instr_ready = 1'b0;
        chk("t6.dropped", instr_valid, 1'b0);
        wait_valid(cyc);
        chk("t6.err_latency", 32'(cyc), 32'd1);
        check_instr("t6.err", 64'd200);
        accept();
        check_halt();
        chk("t6.err_cleared", instr_err, 1'b0);

        gap_mode = 1;
        do_pc_load(64'd1000);
        run_seq(64'd1000, 20);

        gap_mode = 0;
        do_pc_load(64'hFFFF_FFFF_FFFF_FFFC);
        run_seq(64'hFFFF_FFFF_FFFF_FFFC, 4);

        // Redirect while byte 4 of a 10-byte instruction is requested
        do_pc_load(64'd300);
        cyc = 0;
        while (!(mem_req && mem_addr == 64'd304) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("t6.saw_byte4", mem_addr, 64'd304);
        pc_in = 64'd400;
        pc_load = 1'b1;
        @(posedge clk); #1;
        pc_load = 1'b0;
        wait_valid(cyc);
        chk("t6.restart_latency", 32'(cyc), 32'd2);
        check_instr("t6.restart", 64'd400);
        accept();

        // Reset in the middle of fetching the instruction at 402
        repeat (3) @(posedge clk);
        #1;
        chk("t6.midfetch_req", mem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst2.mem_req", mem_req, 1'b0);
        chk("rst2.valid", instr_valid, 1'b0);
        chk("rst2.instruction", instruction, 80'h0);
        chk("rst2.rA", rA, 4'hF);
        chk("rst2.valC", valC, 64'h0);
        chk("rst2.valP", valP, 64'h0);
        chk("rst2.halted", halted, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst2.req_cycle1", mem_req, 1'b1);
        wait_valid(cyc);
        chk("rst2.latency", 32'(cyc + 1), 32'd3);
        check_instr("rst2", 64'd64);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
